// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified-memory port arbiter: bus width, FSM states and
// owner encodings used by the top level and its picker.
package mem_port_arbiter_pkg;

    localparam int WORD = 32;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_REQ  = 2'd1,
        ARB_WAIT = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_e;

endpackage

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Combinational two-way picker: pick=0 selects req_a, pick=1 selects req_b.
// On a tie, round-robin favours the side not granted last; otherwise req_b wins.
module rr_pick2
    import mem_port_arbiter_pkg::*;
(
    input  logic req_a,
    input  logic req_b,
    input  logic last,
    input  logic rr_en,
    output logic pick
);

    // Winner selection, including the tie-break
    always_comb begin
        pick = 1'b0;
        if (req_a && req_b) begin
            if (rr_en) begin
                pick = ~last;
            end else begin
                pick = 1'b1;
            end
        end else if (req_b) begin
            pick = 1'b1;
        end else begin
            pick = 1'b0;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory bus between fetch and data stages, one
// transaction at a time, and drops fetch responses invalidated by a redirect.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int WORD  = mem_port_arbiter_pkg::WORD,
    parameter bit RR_EN = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            if_req,
    input  logic [WORD-1:0] if_addr,
    input  logic            if_flush,
    output logic            if_done,
    output logic [WORD-1:0] if_rdata,
    output logic            if_stall,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [WORD-1:0] d_addr,
    input  logic [WORD-1:0] d_wdata,
    output logic            d_done,
    output logic [WORD-1:0] d_rdata,
    output logic            d_stall,
    output logic            mem_req,
    output logic            mem_we,
    output logic [WORD-1:0] mem_addr,
    output logic [WORD-1:0] mem_wdata,
    input  logic            mem_gnt,
    input  logic            mem_rvalid,
    input  logic [WORD-1:0] mem_rdata,
    output logic            proto_err
);

    arb_state_e      r_state, w_state_nxt;
    owner_e          r_owner, w_owner_nxt;
    logic            r_last, w_last_nxt;
    logic            r_kill, w_kill_nxt;
    logic            r_proto;
    logic            r_mem_req, w_mem_req_nxt;
    logic            r_mem_we, w_mem_we_nxt;
    logic [WORD-1:0] r_mem_addr, w_mem_addr_nxt;
    logic [WORD-1:0] r_mem_wdata, w_mem_wdata_nxt;
    logic            w_if_elig;
    logic            w_pick;
    logic            w_flush_own;

    // A redirect in the same cycle makes the fetch ineligible for this grant
    assign w_if_elig   = if_req & ~if_flush;
    assign w_flush_own = if_flush & (r_owner == OWN_IF);

    rr_pick2 u_pick (
        .req_a (w_if_elig),
        .req_b (d_req),
        .last  (r_last),
        .rr_en (RR_EN),
        .pick  (w_pick)
    );

    // State, ownership and bus output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ARB_IDLE;
            r_owner     <= OWN_IF;
            r_last      <= 1'b0;
            r_kill      <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= {WORD{1'b0}};
            r_mem_wdata <= {WORD{1'b0}};
        end else begin
            r_state     <= w_state_nxt;
            r_owner     <= w_owner_nxt;
            r_last      <= w_last_nxt;
            r_kill      <= w_kill_nxt;
            r_mem_req   <= w_mem_req_nxt;
            r_mem_we    <= w_mem_we_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
        end
    end

    // Next-state: arbitrate in IDLE, hold the request until granted, await response
    always_comb begin
        w_state_nxt     = r_state;
        w_owner_nxt     = r_owner;
        w_last_nxt      = r_last;
        w_kill_nxt      = r_kill;
        w_mem_req_nxt   = r_mem_req;
        w_mem_we_nxt    = r_mem_we;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        case (r_state)
            ARB_IDLE: begin
                if (w_if_elig || d_req) begin
                    w_state_nxt   = ARB_REQ;
                    w_owner_nxt   = owner_e'(w_pick);
                    w_last_nxt    = w_pick;
                    w_kill_nxt    = 1'b0;
                    w_mem_req_nxt = 1'b1;
                    if (w_pick) begin
                        w_mem_we_nxt    = d_we;
                        w_mem_addr_nxt  = d_addr;
                        w_mem_wdata_nxt = d_wdata;
                    end else begin
                        w_mem_we_nxt    = 1'b0;
                        w_mem_addr_nxt  = if_addr;
                        w_mem_wdata_nxt = {WORD{1'b0}};
                    end
                end else begin
                    w_state_nxt = ARB_IDLE;
                end
            end
            ARB_REQ: begin
                if (w_flush_own) begin
                    w_kill_nxt = 1'b1;
                end else begin
                    w_kill_nxt = r_kill;
                end
                if (mem_gnt) begin
                    w_state_nxt   = ARB_WAIT;
                    w_mem_req_nxt = 1'b0;
                end else begin
                    w_state_nxt = ARB_REQ;
                end
            end
            ARB_WAIT: begin
                if (mem_rvalid) begin
                    w_state_nxt = ARB_IDLE;
                    w_kill_nxt  = 1'b0;
                end else if (w_flush_own) begin
                    w_kill_nxt = 1'b1;
                end else begin
                    w_state_nxt = ARB_WAIT;
                end
            end
            default: begin
                w_state_nxt   = ARB_IDLE;
                w_kill_nxt    = 1'b0;
                w_mem_req_nxt = 1'b0;
            end
        endcase
    end

    // Sticky flag for a response arriving when none is outstanding
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_proto <= 1'b0;
        end else if (mem_rvalid && (r_state != ARB_WAIT)) begin
            r_proto <= 1'b1;
        end else begin
            r_proto <= r_proto;
        end
    end

    assign d_done    = mem_rvalid & (r_state == ARB_WAIT) & (r_owner == OWN_D);
    assign if_done   = mem_rvalid & (r_state == ARB_WAIT) & (r_owner == OWN_IF) & ~r_kill & ~if_flush;
    assign if_rdata  = mem_rdata;
    assign d_rdata   = mem_rdata;
    assign if_stall  = if_req & ~if_done;
    assign d_stall   = d_req & ~d_done;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign proto_err = r_proto;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a transaction-level model.
module tb_mem_port_arbiter;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         if_req, if_flush, if_done, if_stall;
    logic [W-1:0] if_addr, if_rdata;
    logic         d_req, d_we, d_done, d_stall;
    logic [W-1:0] d_addr, d_wdata, d_rdata;
    logic         mem_req, mem_we, mem_gnt, mem_rvalid, proto_err;
    logic [W-1:0] mem_addr, mem_wdata, mem_rdata;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int cnt_if_done = 0;
    int cnt_d_done = 0;
    int last_if_cyc = 0;

    // Model: one outstanding transaction described by who owns it and its progress
    bit           m_busy, m_gnted, m_kill, m_owner, m_last, m_proto, m_we;
    logic [W-1:0] m_addr, m_wdata;

    bit           auto_mem;
    int           r_cnt;
    logic [W-1:0] r_addr;
    bit           if_done_seen, d_done_seen;

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush), .if_done(if_done),
        .if_rdata(if_rdata), .if_stall(if_stall),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_done(d_done),
        .d_rdata(d_rdata), .d_stall(d_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .proto_err(proto_err)
    );

    function automatic logic [W-1:0] memf(input logic [W-1:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC3A5_0F96;
    endfunction

    task automatic chk1(input string name, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d actual=%b expected=%b", name, cyc, act, exp);
        end
    endtask

    task automatic chkw(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_gnted = 0; m_kill = 0; m_owner = 0; m_last = 0; m_proto = 0;
        m_we = 0; m_addr = '0; m_wdata = '0;
        r_cnt = 0; r_addr = '0; if_done_seen = 0; d_done_seen = 0;
    endtask

    // Called after inputs are driven for the cycle: compare, then advance the model
    task automatic step();
        bit e_req, e_if, e_d, ie, de, win;
        #1;
        cyc++;
        e_req = m_busy && !m_gnted;
        e_if  = m_busy && m_gnted && mem_rvalid && !m_owner && !m_kill && !if_flush;
        e_d   = m_busy && m_gnted && mem_rvalid && m_owner;
        chk1("mem_req", mem_req, e_req);
        if (e_req) begin
            chk1("mem_we", mem_we, m_we);
            chkw("mem_addr", mem_addr, m_addr);
            if (m_we) chkw("mem_wdata", mem_wdata, m_wdata);
        end
        chk1("if_done", if_done, e_if);
        chk1("d_done", d_done, e_d);
        chk1("if_stall", if_stall, if_req && !e_if);
        chk1("d_stall", d_stall, d_req && !e_d);
        chk1("proto_err", proto_err, m_proto);
        if (auto_mem && e_if) chkw("if_rdata", if_rdata, memf(if_addr));
        if (auto_mem && e_d && !d_we) chkw("d_rdata", d_rdata, memf(d_addr));
        if_done_seen = if_done;
        d_done_seen  = d_done;
        if (if_done) begin cnt_if_done++; last_if_cyc = cyc; end
        if (d_done) cnt_d_done++;

        if (mem_rvalid && !(m_busy && m_gnted)) m_proto = 1;
        if (m_busy) begin
            if (m_gnted && mem_rvalid) begin
                m_busy = 0; m_kill = 0;
            end else begin
                if (!m_owner && if_flush) m_kill = 1;
                if (!m_gnted && mem_gnt) m_gnted = 1;
            end
        end else begin
            ie = if_req && !if_flush;
            de = d_req;
            if (ie || de) begin
                if (ie && de) win = !m_last;
                else          win = de;
                m_busy = 1; m_gnted = 0; m_kill = 0; m_owner = win; m_last = win;
                m_we    = win ? d_we : 1'b0;
                m_addr  = win ? d_addr : if_addr;
                m_wdata = d_wdata;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 0;
        if_req = 0; if_flush = 0; if_addr = '0;
        d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
        mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0;
        model_reset();
        @(negedge clk);
        reset = 1;
    endtask

    // Entered in the first cycle of a bus request; completes it and checks the done pulse
    task automatic serve(input int gw, input int rw, input logic [W-1:0] rd, input bit ewe,
                         input logic [W-1:0] eaddr, input logic [W-1:0] ewd, input bit ed);
        for (int i = 0; i <= gw; i++) begin
            mem_gnt = (i == gw);
            step();
            chk1("req_held", mem_req, 1'b1);
            chkw("req_addr", mem_addr, eaddr);
            chk1("req_we", mem_we, ewe);
            if (ewe) chkw("req_wdata", mem_wdata, ewd);
            chk1("req_stall", ed ? d_stall : if_stall, 1'b1);
            @(negedge clk);
        end
        mem_gnt = 0;
        for (int i = 1; i < rw; i++) begin
            step();
            chk1("wait_req_low", mem_req, 1'b0);
            @(negedge clk);
        end
        mem_rvalid = 1; mem_rdata = rd;
        step();
        chk1("done_pulse", ed ? d_done : if_done, 1'b1);
        if (!ewe) chkw("rdata", ed ? d_rdata : if_rdata, rd);
        @(negedge clk);
        mem_rvalid = 0; mem_rdata = '0;
    endtask

    task automatic drive_rand();
        mem_gnt = 0; mem_rvalid = 0; mem_rdata = $urandom;
        if (r_cnt > 0) begin
            r_cnt--;
            if (r_cnt == 0) begin mem_rvalid = 1; mem_rdata = memf(r_addr); end
        end else if (mem_req && ($urandom_range(0, 2) != 0)) begin
            mem_gnt = 1; r_cnt = $urandom_range(1, 3); r_addr = mem_addr;
        end
        if_flush = 0;
        if (if_done_seen) if_req = 0;
        if (!if_req && ($urandom_range(0, 2) == 0)) begin
            if_req = 1; if_addr = $urandom & 32'hFFFF_FFFC;
        end else if (if_req && ($urandom_range(0, 9) == 0)) begin
            if_flush = 1; if_addr = $urandom & 32'hFFFF_FFFC;
        end
        if (d_done_seen) d_req = 0;
        if (!d_req && ($urandom_range(0, 2) == 0)) begin
            d_req = 1; d_we = $urandom_range(0, 1);
            d_addr = $urandom & 32'hFFFF_FFFC; d_wdata = $urandom;
        end
    endtask

    initial begin
        int s, n0, nd;
        reset = 0; auto_mem = 0;
        if_req = 0; if_flush = 0; if_addr = '0;
        d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
        mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0;
        model_reset();
        @(negedge clk);
        #1;
        chk1("rst_mem_req", mem_req, 1'b0);
        chk1("rst_mem_we", mem_we, 1'b0);
        chkw("rst_mem_addr", mem_addr, 32'h0);
        chkw("rst_mem_wdata", mem_wdata, 32'h0);
        chk1("rst_if_done", if_done, 1'b0);
        chk1("rst_d_done", d_done, 1'b0);
        chk1("rst_proto", proto_err, 1'b0);
        @(negedge clk);
        reset = 1;

        // Fetch only: done two cycles after the request is sampled
        nd = cnt_d_done;
        if_req = 1; if_addr = 32'h40; step(); s = cyc; @(negedge clk);
        n0 = cnt_if_done;
        serve(0, 1, 32'h0050_0093, 1'b0, 32'h40, 32'h0, 1'b0);
        chkw("t1_if_done_cnt", cnt_if_done - n0, 32'd1);
        chkw("t1_latency", last_if_cyc - s, 32'd2);
        if_req = 0; step(); @(negedge clk);
        chkw("t1_d_done_cnt", cnt_d_done - nd, 32'd0);

        // Tie from reset: data first, then fetch, next tie to data again
        do_reset();
        if_req = 1; if_addr = 32'h200;
        d_req = 1; d_we = 1; d_addr = 32'h100; d_wdata = 32'hDEAD;
        step(); @(negedge clk);
        serve(0, 1, 32'h0, 1'b1, 32'h100, 32'hDEAD, 1'b1);
        d_req = 0; step(); @(negedge clk);
        serve(0, 1, 32'h13, 1'b0, 32'h200, 32'h0, 1'b0);
        if_addr = 32'h204; d_req = 1; d_we = 0; d_addr = 32'h104;
        step(); @(negedge clk);
        serve(0, 2, 32'h1234, 1'b0, 32'h104, 32'h0, 1'b1);
        d_req = 0; step(); @(negedge clk);
        serve(0, 1, 32'h33, 1'b0, 32'h204, 32'h0, 1'b0);
        if_req = 0; step(); @(negedge clk);

        // Grant withheld for five cycles
        do_reset();
        n0 = cnt_if_done;
        if_req = 1; if_addr = 32'h500; step(); @(negedge clk);
        serve(5, 1, 32'h77, 1'b0, 32'h500, 32'h0, 1'b0);
        chkw("t3_done_once", cnt_if_done - n0, 32'd1);
        if_req = 0; step(); @(negedge clk);

        // Redirect while the fetch is outstanding
        do_reset();
        if_req = 1; if_addr = 32'h300; step(); @(negedge clk);
        mem_gnt = 1; step(); @(negedge clk); mem_gnt = 0;
        n0 = cnt_if_done;
        if_flush = 1; if_addr = 32'h400; step(); @(negedge clk); if_flush = 0;
        step(); @(negedge clk);
        step(); @(negedge clk);
        mem_rvalid = 1; mem_rdata = 32'hBAD; step();
        chk1("t4_killed_done", if_done, 1'b0);
        @(negedge clk); mem_rvalid = 0;
        chkw("t4_no_done", cnt_if_done - n0, 32'd0);
        step(); @(negedge clk);
        serve(0, 1, 32'h600, 1'b0, 32'h400, 32'h0, 1'b0);
        chkw("t4_refetch", cnt_if_done - n0, 32'd1);
        if_req = 0; step(); @(negedge clk);

        // Spurious response while idle
        do_reset();
        mem_rvalid = 1; step(); @(negedge clk); mem_rvalid = 0;
        step();
        chk1("t5_proto_set", proto_err, 1'b1);
        chk1("t5_idle", mem_req, 1'b0);
        @(negedge clk);
        repeat (3) begin step(); @(negedge clk); end
        #1 chk1("t5_proto_sticky", proto_err, 1'b1);
        do_reset();
        step();
        chk1("t5_proto_cleared", proto_err, 1'b0);
        @(negedge clk);

        // Reset asserted while the request is on the bus
        do_reset();
        if_req = 1; if_addr = 32'h700; step(); @(negedge clk);
        step();
        chk1("t6_in_req", mem_req, 1'b1);
        #2 reset = 0;
        #1 chk1("t6_async_clear", mem_req, 1'b0);
        model_reset();
        @(negedge clk);
        reset = 1;
        step(); @(negedge clk);
        serve(0, 1, 32'h99, 1'b0, 32'h700, 32'h0, 1'b0);
        if_req = 0; step(); @(negedge clk);

        // Randomized traffic against the model
        do_reset();
        auto_mem = 1;
        n0 = cnt_if_done; nd = cnt_d_done;
        repeat (3000) begin
            drive_rand();
            step();
            @(negedge clk);
        end
        chk1("rand_if_progress", (cnt_if_done - n0) > 50, 1'b1);
        chk1("rand_d_progress", (cnt_d_done - nd) > 50, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
